// File: rtl/carry_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : carry_accumulator                                               |
// | Purpose  : Sums DEPTH operands {c_out,sum} into an ACC_W-bit result with   |
// |            sticky overflow and a valid/ready result handoff.               |
// |            Define ACC_SAT_EN to clamp on overflow instead of wrapping.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module carry_accumulator #(
    parameter int N     = 8,
    parameter int ACC_W = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     sum,
    input  logic             c_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [7:0]       count,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] c_depth = 8'(DEPTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [7:0]       r_count;
    logic [7:0]       w_count_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic             r_out_valid;
    logic             w_out_valid_nxt;

    logic [ACC_W-1:0] w_operand;
    logic [ACC_W:0]   w_sum_ext;
    logic [ACC_W-1:0] w_acc_add;
    logic             w_carry;
    logic             w_last;

    always_comb begin
        w_operand        = '0;
        w_operand[N:0]   = {c_out, sum};
    end

    // One extra bit exposes the carry out of the accumulator for overflow.
    assign w_sum_ext = {1'b0, r_acc} + {1'b0, w_operand};
    assign w_carry   = w_sum_ext[ACC_W];
    assign w_last    = ((r_count + 8'd1) == c_depth);

`ifdef ACC_SAT_EN
    assign w_acc_add = w_carry ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
`else
    assign w_acc_add = w_sum_ext[ACC_W-1:0];
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_count_nxt     = r_count;
        w_ovf_nxt       = r_ovf;
        w_out_valid_nxt = r_out_valid;

        if (clear) begin
            // Abort wins over any acceptance or handoff on the same edge.
            w_state_nxt     = IDLE;
            w_acc_nxt       = '0;
            w_count_nxt     = '0;
            w_ovf_nxt       = 1'b0;
            w_out_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (in_valid) begin
                        w_acc_nxt   = w_acc_add;
                        w_count_nxt = r_count + 8'd1;
                        w_ovf_nxt   = r_ovf | w_carry;
                        if (w_last) begin
                            w_state_nxt     = DONE;
                            w_out_valid_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        w_state_nxt     = IDLE;
                        w_acc_nxt       = '0;
                        w_count_nxt     = '0;
                        w_ovf_nxt       = 1'b0;
                        w_out_valid_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt     = IDLE;
                    w_acc_nxt       = '0;
                    w_count_nxt     = '0;
                    w_ovf_nxt       = 1'b0;
                    w_out_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_count     <= w_count_nxt;
            r_ovf       <= w_ovf_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    assign in_ready  = (r_state != DONE);
    assign out_valid = r_out_valid;
    assign acc_out   = r_acc;
    assign count     = r_count;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_carry_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_carry_accumulator                                            |
// | Purpose  : Scoreboard bench for three carry_accumulator configurations     |
// |            (12b/depth 4, 10b/depth 4, 12b/depth 1) on shared stimulus.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_carry_accumulator;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       clear     = 1'b0;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b0;
    logic       c_out     = 1'b0;
    logic [7:0] sum       = 8'd0;

    always #5 clk = ~clk;

    logic        rdy_a, rdy_b, rdy_c;
    logic        ov_a, ov_b, ov_c;
    logic        ovf_a, ovf_b, ovf_c;
    logic [11:0] acc_a, acc_c;
    logic [9:0]  acc_b;
    logic [7:0]  cnt_a, cnt_b, cnt_c;

    carry_accumulator #(.N(8), .ACC_W(12), .DEPTH(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy_a),
        .sum(sum), .c_out(c_out), .out_valid(ov_a), .out_ready(out_ready),
        .acc_out(acc_a), .count(cnt_a), .ovf(ovf_a));

    carry_accumulator #(.N(8), .ACC_W(10), .DEPTH(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy_b),
        .sum(sum), .c_out(c_out), .out_valid(ov_b), .out_ready(out_ready),
        .acc_out(acc_b), .count(cnt_b), .ovf(ovf_b));

    carry_accumulator #(.N(8), .ACC_W(12), .DEPTH(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy_c),
        .sum(sum), .c_out(c_out), .out_valid(ov_c), .out_ready(out_ready),
        .acc_out(acc_c), .count(cnt_c), .ovf(ovf_c));

    logic [31:0] o_acc [3];
    logic [31:0] o_cnt [3];
    logic        o_rdy [3];
    logic        o_ov  [3];
    logic        o_ovf [3];

    assign o_acc[0] = {20'd0, acc_a};
    assign o_acc[1] = {22'd0, acc_b};
    assign o_acc[2] = {20'd0, acc_c};
    assign o_cnt[0] = {24'd0, cnt_a};
    assign o_cnt[1] = {24'd0, cnt_b};
    assign o_cnt[2] = {24'd0, cnt_c};
    assign o_rdy[0] = rdy_a;
    assign o_rdy[1] = rdy_b;
    assign o_rdy[2] = rdy_c;
    assign o_ov[0]  = ov_a;
    assign o_ov[1]  = ov_b;
    assign o_ov[2]  = ov_c;
    assign o_ovf[0] = ovf_a;
    assign o_ovf[1] = ovf_b;
    assign o_ovf[2] = ovf_c;

`ifdef ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: state after the next rising edge, updated as stimulus is driven.
    int          m_st  [3];
    longint      m_acc [3];
    int          m_cnt [3];
    logic        m_ovf [3];
    logic        seen  [3];
    logic [40:0] q0[$];
    logic [40:0] q1[$];
    logic [40:0] q2[$];

    function automatic int acc_w_of(input int i);
        return (i == 1) ? 10 : 12;
    endfunction

    function automatic int depth_of(input int i);
        return (i == 2) ? 1 : 4;
    endfunction

    task automatic sb_push(input int i, input logic [40:0] v);
        case (i)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    function automatic int sb_size(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic sb_pop(input int i, output logic [40:0] v);
        case (i)
            0: v = q0.pop_front();
            1: v = q1.pop_front();
            default: v = q2.pop_front();
        endcase
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_st[i]  = 0;
            m_acc[i] = 0;
            m_cnt[i] = 0;
            m_ovf[i] = 1'b0;
        end
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    task automatic model_step(input int i);
        longint lim;
        longint t;
        lim = longint'(1) << acc_w_of(i);
        if (clear) begin
            m_st[i]  = 0;
            m_acc[i] = 0;
            m_cnt[i] = 0;
            m_ovf[i] = 1'b0;
        end else if (m_st[i] != 2) begin
            if (in_valid) begin
                t = m_acc[i] + longint'({c_out, sum});
                if (t >= lim) begin
                    m_ovf[i] = 1'b1;
                    t = SAT ? (lim - 1) : (t - lim);
                end
                m_acc[i] = t;
                m_cnt[i] = m_cnt[i] + 1;
                if (m_cnt[i] == depth_of(i)) begin
                    m_st[i] = 2;
                    sb_push(i, {m_ovf[i], m_cnt[i][7:0], m_acc[i][31:0]});
                end else begin
                    m_st[i] = 1;
                end
            end
        end else if (out_ready) begin
            m_st[i]  = 0;
            m_acc[i] = 0;
            m_cnt[i] = 0;
            m_ovf[i] = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [40:0] e;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("%s.in_ready[%0d]", tag, i), o_rdy[i], (m_st[i] != 2));
            check_eq($sformatf("%s.out_valid[%0d]", tag, i), o_ov[i], (m_st[i] == 2));
            check_eq($sformatf("%s.acc[%0d]", tag, i), o_acc[i], m_acc[i][31:0]);
            check_eq($sformatf("%s.count[%0d]", tag, i), o_cnt[i], m_cnt[i]);
            check_eq($sformatf("%s.ovf[%0d]", tag, i), o_ovf[i], m_ovf[i]);
            if (o_ov[i] && !seen[i]) begin
                seen[i] = 1'b1;
                check_eq($sformatf("%s.sb_avail[%0d]", tag, i), (sb_size(i) > 0), 1);
                if (sb_size(i) > 0) begin
                    sb_pop(i, e);
                    check_eq($sformatf("%s.sb_acc[%0d]", tag, i), o_acc[i], e[31:0]);
                    check_eq($sformatf("%s.sb_count[%0d]", tag, i), o_cnt[i], {24'd0, e[39:32]});
                    check_eq($sformatf("%s.sb_ovf[%0d]", tag, i), o_ovf[i], e[40]);
                end
            end else if (!o_ov[i]) begin
                seen[i] = 1'b0;
            end
        end
    endtask

    task automatic apply(input logic v, input logic [7:0] s, input logic co,
                         input logic ordy, input logic clr);
        in_valid  = v;
        sum       = s;
        c_out     = co;
        out_ready = ordy;
        clear     = clr;
        for (int i = 0; i < 3; i++) model_step(i);
    endtask

    task automatic step(input string tag, input logic v, input logic [7:0] s, input logic co,
                        input logic ordy, input logic clr);
        @(negedge clk);
        check_all(tag);
        apply(v, s, co, ordy, clr);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) seen[i] = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");

        // Release and present the first operand on the same negedge.
        rst_n = 1'b1;
        apply(1'b1, 8'h78, 1'b1, 1'b0, 1'b0);
        repeat (3) step("blk78", 1'b1, 8'h78, 1'b1, 1'b0, 1'b0);
        repeat (5) step("hold", 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        step("handoff", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step("idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        repeat (4) step("ovf1ff", 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        step("ovfwait", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step("ovfhand", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step("idle2", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        repeat (2) step("pre_clr", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        step("clr", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
        step("post_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        repeat (2) step("pre_rst", 1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        step("pre_rst_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        #2 rst_n = 1'b1;
        repeat (4) step("post_rst", 1'b1, 8'($urandom), 1'($urandom), 1'b0, 1'b0);
        step("post_rst_w", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step("post_rst_i", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 300; k++) begin
            step("rand", ($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 39) == 0));
        end

        repeat (3) step("drain", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_all("final");
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("sb_left[%0d]", i), sb_size(i), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
